instr_mem_bank_ctrl: RTL and testbench

Parametrised instruction-memory controller for the core's instruction port. It replaces the single-RAM plus boot-ROM arrangement with NUM_BANKS word-interleaved RAM banks and a boot-ROM region, fronted by a req/gnt/rvalid/rready handshake. It tracks in-flight accesses, returns responses in order through a response FIFO, and applies backpressure through gnt_o. It sits between the core instruction/debug bus and the external single-port RAM macros and boot ROM, all of which have 1-cycle read latency.

---
 rtl/instr_mem_pkg.sv | 28 ++
 rtl/instr_mem_resp_fifo.sv | 65 ++++++
 rtl/instr_mem_bank_ctrl.sv | 168 ++++++++++++++++
 tb/tb_instr_mem_bank_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and sizing for the banked instruction-memory controller.
// The structs are sized from the default build parameters below. The top
// module takes its parameter defaults from here, so a non-default build
// should change these values together with the top-level overrides.
package instr_mem_pkg;

   localparam int RAM_SIZE_DEF   = 32768;
   localparam int NUM_BANKS_DEF  = 4;
   localparam int DATA_WIDTH_DEF = 32;

   // A single bank still needs a 1-bit index field so the struct stays legal
   localparam int BANK_IDX_W = (NUM_BANKS_DEF > 1) ? $clog2(NUM_BANKS_DEF) : 1;
   localparam int BANK_AW    = $clog2(RAM_SIZE_DEF / NUM_BANKS_DEF);

   typedef struct packed {
      logic [DATA_WIDTH_DEF-1:0] rdata;
      logic                      err;
   } resp_t;

   typedef struct packed {
      logic                  valid;
      logic                  is_rom;
      logic [BANK_IDX_W-1:0] bank_idx;
      logic                  is_write;
      logic                  err;
   } inflight_t;

endpackage

// File: rtl/instr_mem_resp_fifo.sv
// In-order response FIFO. Synchronous push/pop, async active-high reset.
// The head entry is always visible on rdata; rdata is meaningless while empty.
module instr_mem_resp_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 33
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Entry storage; contents need no reset because count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_mem_bank_ctrl.sv
// Instruction-memory controller: NUM_BANKS word-interleaved RAM banks plus a
// boot-ROM region (address MSB set), behind a req/gnt/rvalid/rready port.
// All macros have 1-cycle read latency. Each accepted access spends one
// cycle in the in-flight stage; its data is then either handed straight to
// the response port (FIFO empty) or queued behind older responses.
//
// Build option INSTR_MEM_ROM_WP_EN: when defined, writes to the ROM region
// answer with err_o=1; otherwise they are silently dropped (err_o=0).
module instr_mem_bank_ctrl
   import instr_mem_pkg::*;
#(
   parameter  int RAM_SIZE       = RAM_SIZE_DEF,
   parameter  int NUM_BANKS      = NUM_BANKS_DEF,
   parameter  int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter  int ROM_ADDR_WIDTH = 12,
   parameter  int RESP_DEPTH     = 2,
   parameter  int ADDR_WIDTH     = $clog2(RAM_SIZE) + 1,
   localparam int BANK_ADDR_W    = $clog2(RAM_SIZE / NUM_BANKS)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            req_i,
   output logic                            gnt_o,
   input  logic [ADDR_WIDTH-1:0]           addr_i,
   input  logic                            we_i,
   input  logic [DATA_WIDTH/8-1:0]         be_i,
   input  logic [DATA_WIDTH-1:0]           wdata_i,
   output logic                            rvalid_o,
   input  logic                            rready_i,
   output logic [DATA_WIDTH-1:0]           rdata_o,
   output logic                            err_o,
   output logic [NUM_BANKS-1:0]            bank_en_o,
   output logic [BANK_ADDR_W-1:0]          bank_addr_o,
   output logic                            bank_we_o,
   output logic [DATA_WIDTH/8-1:0]         bank_be_o,
   output logic [DATA_WIDTH-1:0]           bank_wdata_o,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rdata_i,
   output logic                            rom_en_o,
   output logic [ROM_ADDR_WIDTH-1:0]       rom_addr_o,
   input  logic [DATA_WIDTH-1:0]           rom_rdata_i
);

   localparam int BANK_SHIFT = $clog2(NUM_BANKS);
   localparam int IDX_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int CNT_W      = $clog2(RESP_DEPTH + 1);
   localparam int RESP_W     = $bits(resp_t);

`ifdef INSTR_MEM_ROM_WP_EN
   localparam bit ROM_WP = 1'b1;
`else
   localparam bit ROM_WP = 1'b0;
`endif

   logic             is_rom_req;
   logic             accept;
   logic [IDX_W-1:0] req_bank;
   logic [CNT_W-1:0] cnt;
   logic             resp_pop;

   inflight_t        infl;
   resp_t            infl_resp;
   resp_t            fifo_head;
   resp_t            resp_head;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;

   // ---------------------------------------------------------------------
   // Request side: admission and address decode
   // ---------------------------------------------------------------------
   assign is_rom_req = addr_i[ADDR_WIDTH-1];
   assign req_bank   = (NUM_BANKS > 1) ? addr_i[2 +: IDX_W] : '0;

   // cnt covers the in-flight stage as well as queued entries, so a pop only
   // frees a slot once the count register has actually dropped.
   assign gnt_o  = req_i && !rst && (cnt < CNT_W'(RESP_DEPTH));
   assign accept = req_i && gnt_o;

   // One-hot bank enable for RAM-region accesses in the accept cycle
   always_comb begin
      bank_en_o = '0;
      if (accept && !is_rom_req) begin
         bank_en_o[req_bank] = 1'b1;
      end
   end

   // Upper word-index bits select the row inside the bank; byte offset dropped
   assign bank_addr_o  = {addr_i[2+BANK_SHIFT +: BANK_ADDR_W-2], 2'b00};
   assign bank_we_o    = we_i;
   assign bank_be_o    = be_i;
   assign bank_wdata_o = wdata_i;

   // ROM is read-only: writes never reach the macro in either build
   assign rom_en_o   = accept && is_rom_req && !we_i;
   assign rom_addr_o = addr_i[ROM_ADDR_WIDTH-1:0];

   // Capture what the returning data will need one cycle later
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         infl <= '0;
      end else begin
         infl.valid    <= accept;
         infl.is_rom   <= is_rom_req;
         infl.bank_idx <= req_bank;
         infl.is_write <= we_i;
         infl.err      <= ROM_WP && is_rom_req && we_i;
      end
   end

   // Occupancy: +1 on accept, -1 on consumed response, unchanged on both
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         case ({accept, resp_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Response side
   // ---------------------------------------------------------------------

   // Pick the macro data for the access now leaving the in-flight stage
   always_comb begin
      infl_resp = '0;
      if (infl.valid) begin
         infl_resp.err = infl.err;
         if (!infl.is_write) begin
            infl_resp.rdata = infl.is_rom ? rom_rdata_i
                            : bank_rdata_i[infl.bank_idx*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // With an empty queue the in-flight result is presented directly, which
   // gives the 1-cycle accept-to-rvalid latency. If it is not consumed it is
   // queued and becomes the (unchanged) head next cycle. The full check is
   // defensive: admission control keeps the queue from filling while the
   // in-flight stage is occupied.
   assign fifo_push = infl.valid && !fifo_full && !(fifo_empty && rready_i);
   assign fifo_pop  = !fifo_empty && rready_i;

   instr_mem_resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .WIDTH (RESP_W)
   ) u_resp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (infl_resp),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign resp_head = fifo_empty ? infl_resp : fifo_head;
   assign rvalid_o  = !fifo_empty || infl.valid;
   assign rdata_o   = resp_head.rdata;
   assign err_o     = resp_head.err;
   assign resp_pop  = rvalid_o && rready_i;

endmodule

// File: tb/tb_instr_mem_bank_ctrl.sv
// Self-checking bench for instr_mem_bank_ctrl (default parameters).
// Expected read data comes from a flat word-indexed shadow memory; the bank
// macro models are addressed only through the DUT's bank outputs, so a decode
// error shows up as wrong data.
module tb_instr_mem_bank_ctrl;

   localparam int NB     = 4;
   localparam int DW     = 32;
   localparam int AW     = 16;
   localparam int RAW    = 12;
   localparam int BAW    = 13;
   localparam int WORDS  = 8192;
   localparam int BWORDS = 2048;

`ifdef INSTR_MEM_ROM_WP_EN
   localparam bit WP = 1'b1;
`else
   localparam bit WP = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic              req_i;
   logic              gnt_o;
   logic [AW-1:0]     addr_i;
   logic              we_i;
   logic [3:0]        be_i;
   logic [DW-1:0]     wdata_i;
   logic              rvalid_o;
   logic              rready_i;
   logic [DW-1:0]     rdata_o;
   logic              err_o;
   logic [NB-1:0]     bank_en_o;
   logic [BAW-1:0]    bank_addr_o;
   logic              bank_we_o;
   logic [3:0]        bank_be_o;
   logic [DW-1:0]     bank_wdata_o;
   logic [NB*DW-1:0]  bank_rdata_i;
   logic              rom_en_o;
   logic [RAW-1:0]    rom_addr_o;
   logic [DW-1:0]     rom_rdata_i;

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   passed = 0;

   // Bank macro model storage (written only by the model)
   logic [DW-1:0] bmem [NB][BWORDS];
   bit   [NB-1:0] bwritten [BWORDS];
   // Bench shadow memory indexed by global word (written only by stimulus)
   logic [DW-1:0] shadow [WORDS];
   bit            swritten [WORDS];

   instr_mem_bank_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .req_i        (req_i),
      .gnt_o        (gnt_o),
      .addr_i       (addr_i),
      .we_i         (we_i),
      .be_i         (be_i),
      .wdata_i      (wdata_i),
      .rvalid_o     (rvalid_o),
      .rready_i     (rready_i),
      .rdata_o      (rdata_o),
      .err_o        (err_o),
      .bank_en_o    (bank_en_o),
      .bank_addr_o  (bank_addr_o),
      .bank_we_o    (bank_we_o),
      .bank_be_o    (bank_be_o),
      .bank_wdata_o (bank_wdata_o),
      .bank_rdata_i (bank_rdata_i),
      .rom_en_o     (rom_en_o),
      .rom_addr_o   (rom_addr_o),
      .rom_rdata_i  (rom_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_word(input int w);
      logic [15:0] wl;
      wl = w[15:0];
      return {16'hA5C3 ^ wl, wl};
   endfunction

   function automatic logic [DW-1:0] rom_word(input logic [RAW-1:0] a);
      return 32'h5A00_0000 | {20'h0, a};
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] cur,
                                           input logic [DW-1:0] wd,
                                           input logic [3:0]    be);
      logic [DW-1:0] r;
      r = cur;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      end
      return r;
   endfunction

   // Macro models: 1-cycle read latency, byte-enabled writes
   always @(posedge clk) begin
      for (int k = 0; k < NB; k++) begin
         if (bank_en_o[k]) begin
            if (bank_we_o) begin
               bmem[k][bank_addr_o[BAW-1:2]] <= merge(
                  bwritten[bank_addr_o[BAW-1:2]][k] ? bmem[k][bank_addr_o[BAW-1:2]]
                                                   : init_word(int'(bank_addr_o[BAW-1:2]) * NB + k),
                  bank_wdata_o, bank_be_o);
               bwritten[bank_addr_o[BAW-1:2]][k] <= 1'b1;
            end else begin
               bank_rdata_i[k*DW +: DW] <= bwritten[bank_addr_o[BAW-1:2]][k]
                                           ? bmem[k][bank_addr_o[BAW-1:2]]
                                           : init_word(int'(bank_addr_o[BAW-1:2]) * NB + k);
            end
         end
      end
      if (rom_en_o) rom_rdata_i <= rom_word(rom_addr_o);
   end

   // Scoreboard: every consumed response is compared with the oldest expectation
   always @(negedge clk) begin
      if (!rst && rvalid_o && rready_i) begin
         checks++;
         if (sb_q.size() == 0) begin
            $display("FAIL resp_unexpected: got rdata=%h err=%b, no response expected", rdata_o, err_o);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (rdata_o !== e.rdata || err_o !== e.err)
               $display("FAIL resp_data: got rdata=%h err=%b, expected rdata=%h err=%b",
                        rdata_o, err_o, e.rdata, e.err);
            else
               passed++;
         end
      end
   end

   // Present one request for one cycle; report what the DUT showed mid-cycle
   task automatic issue(input logic [AW-1:0] a, input logic we, input logic [3:0] be,
                        input logic [DW-1:0] wd, output logic g, output logic [NB-1:0] ben,
                        output logic [BAW-1:0] baddr, output logic ren,
                        output logic [RAW-1:0] raddr, output logic rv);
      exp_t e;
      int   w;
      req_i = 1'b1; addr_i = a; we_i = we; be_i = be; wdata_i = wd;
      @(negedge clk);
      g = gnt_o; ben = bank_en_o; baddr = bank_addr_o;
      ren = rom_en_o; raddr = rom_addr_o; rv = rvalid_o;
      if (g) begin
         w = int'(a[AW-2:2]);
         e.rdata = '0;
         e.err   = 1'b0;
         if (we) begin
            e.err = a[AW-1] && WP;
            if (!a[AW-1]) begin
               shadow[w]   = merge(swritten[w] ? shadow[w] : init_word(w), wd, be);
               swritten[w] = 1'b1;
            end
         end else if (a[AW-1]) begin
            e.rdata = rom_word(a[RAW-1:0]);
         end else begin
            e.rdata = swritten[w] ? shadow[w] : init_word(w);
         end
         sb_q.push_back(e);
      end
      @(posedge clk); #1;
      req_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      rready_i = 1'b1;
      @(negedge clk);
      while (sb_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb_q.size() != 0)
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb_q.size());
      else
         passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      req_i = 1'b1; addr_i = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (gnt_o !== 1'b0)     $display("FAIL rst_gnt: got %b, expected 0", gnt_o); else passed++;
      checks++; if (rvalid_o !== 1'b0)  $display("FAIL rst_rvalid: got %b, expected 0", rvalid_o); else passed++;
      checks++; if (rdata_o !== '0)     $display("FAIL rst_rdata: got %h, expected 0", rdata_o); else passed++;
      checks++; if (err_o !== 1'b0)     $display("FAIL rst_err: got %b, expected 0", err_o); else passed++;
      checks++; if (bank_en_o !== '0)   $display("FAIL rst_bank_en: got %b, expected 0", bank_en_o); else passed++;
      checks++; if (rom_en_o !== 1'b0)  $display("FAIL rst_rom_en: got %b, expected 0", rom_en_o); else passed++;
      @(posedge clk); #1;
      req_i = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_interleave();
      logic g, ren, rv;
      logic [NB-1:0] ben;
      logic [BAW-1:0] baddr;
      logic [RAW-1:0] raddr;
      rready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         issue(AW'(i * 4), 1'b0, 4'hF, '0, g, ben, baddr, ren, raddr, rv);
         checks++; if (ben !== NB'(1 << (i % NB)))
            $display("FAIL il_bank_en[%0d]: got %b, expected %b", i, ben, NB'(1 << (i % NB))); else passed++;
         checks++; if (baddr !== BAW'((i / NB) * 4))
            $display("FAIL il_bank_addr[%0d]: got %h, expected %h", i, baddr, BAW'((i / NB) * 4)); else passed++;
         checks++; if (rv !== (i > 0))
            $display("FAIL il_latency[%0d]: rvalid got %b, expected %b", i, rv, (i > 0)); else passed++;
      end
      @(negedge clk);
      checks++; if (rvalid_o !== 1'b1) $display("FAIL il_last_rvalid: got %b, expected 1", rvalid_o); else passed++;
      @(posedge clk); #1;
      drain();
      checks++; if (rvalid_o !== 1'b0) $display("FAIL il_idle_rvalid: got %b, expected 0", rvalid_o); else passed++;
   endtask

   task automatic test_backpressure();
      logic g, ren, rv;
      logic [NB-1:0] ben;
      logic [BAW-1:0] baddr;
      logic [RAW-1:0] raddr;
      logic [DW-1:0] head_exp;
      rready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         issue(AW'(16'h0040 + i * 4), 1'b0, 4'hF, '0, g, ben, baddr, ren, raddr, rv);
         checks++; if (g !== (i < 2))
            $display("FAIL bp_gnt[%0d]: got %b, expected %b", i, g, (i < 2)); else passed++;
         if (i >= 2) begin
            head_exp = sb_q[0].rdata;
            checks++; if (rdata_o !== head_exp)
               $display("FAIL bp_head_hold[%0d]: got %h, expected %h", i, rdata_o, head_exp); else passed++;
         end
      end
      rready_i = 1'b1;
      issue(16'h0080, 1'b0, 4'hF, '0, g, ben, baddr, ren, raddr, rv);
      checks++; if (g !== 1'b0) $display("FAIL bp_gnt_on_pop: got %b, expected 0", g); else passed++;
      rready_i = 1'b0;
      issue(16'h0080, 1'b0, 4'hF, '0, g, ben, baddr, ren, raddr, rv);
      checks++; if (g !== 1'b1) $display("FAIL bp_gnt_after_pop: got %b, expected 1", g); else passed++;
      issue(16'h0084, 1'b0, 4'hF, '0, g, ben, baddr, ren, raddr, rv);
      checks++; if (g !== 1'b0) $display("FAIL bp_gnt_refull: got %b, expected 0", g); else passed++;
      drain();
   endtask

   task automatic test_back_to_back();
      logic g, ren, rv;
      logic [NB-1:0] ben;
      logic [BAW-1:0] baddr;
      logic [RAW-1:0] raddr;
      rready_i = 1'b0;
      issue(16'h0100, 1'b0, 4'hF, '0, g, ben, baddr, ren, raddr, rv);
      checks++; if (g !== 1'b1) $display("FAIL b2b_gnt0: got %b, expected 1", g); else passed++;
      rready_i = 1'b1;
      issue(16'h0104, 1'b0, 4'hF, '0, g, ben, baddr, ren, raddr, rv);
      checks++; if (g !== 1'b1 || rv !== 1'b1)
         $display("FAIL b2b_accept_pop: gnt=%b rvalid=%b, expected 1 1", g, rv); else passed++;
      rready_i = 1'b0;
      issue(16'h0108, 1'b0, 4'hF, '0, g, ben, baddr, ren, raddr, rv);
      checks++; if (g !== 1'b1) $display("FAIL b2b_gnt2: got %b, expected 1", g); else passed++;
      issue(16'h010C, 1'b0, 4'hF, '0, g, ben, baddr, ren, raddr, rv);
      checks++; if (g !== 1'b0) $display("FAIL b2b_gnt3: got %b, expected 0", g); else passed++;
      drain();
   endtask

   task automatic test_ram_write();
      logic g, ren, rv;
      logic [NB-1:0] ben;
      logic [BAW-1:0] baddr;
      logic [RAW-1:0] raddr;
      rready_i = 1'b1;
      issue(16'h0024, 1'b1, 4'b0101, 32'h1122_3344, g, ben, baddr, ren, raddr, rv);
      checks++; if (ben !== 4'b0010 || baddr !== 13'h0008)
         $display("FAIL wr_decode: bank_en=%b bank_addr=%h, expected 0010 0008", ben, baddr); else passed++;
      issue(16'h0024, 1'b0, 4'hF, '0, g, ben, baddr, ren, raddr, rv);
      issue(16'h0028, 1'b0, 4'hF, '0, g, ben, baddr, ren, raddr, rv);
      drain();
   endtask

   task automatic test_rom();
      logic g, ren, rv;
      logic [NB-1:0] ben;
      logic [BAW-1:0] baddr;
      logic [RAW-1:0] raddr;
      rready_i = 1'b1;
      issue(16'h8010, 1'b0, 4'hF, '0, g, ben, baddr, ren, raddr, rv);
      checks++; if (g !== 1'b1 || ren !== 1'b1 || raddr !== 12'h010 || ben !== '0)
         $display("FAIL rom_read_ctrl: gnt=%b rom_en=%b rom_addr=%h bank_en=%b, expected 1 1 010 0000",
                  g, ren, raddr, ben); else passed++;
      issue(16'h8010, 1'b1, 4'hF, 32'hDEAD_BEEF, g, ben, baddr, ren, raddr, rv);
      checks++; if (g !== 1'b1 || ren !== 1'b0 || ben !== '0)
         $display("FAIL rom_write_ctrl: gnt=%b rom_en=%b bank_en=%b, expected 1 0 0000",
                  g, ren, ben); else passed++;
      issue(16'h8FFC, 1'b0, 4'hF, '0, g, ben, baddr, ren, raddr, rv);
      drain();
   endtask

   task automatic test_reset_mid_burst();
      logic g, ren, rv;
      logic [NB-1:0] ben;
      logic [BAW-1:0] baddr;
      logic [RAW-1:0] raddr;
      rready_i = 1'b0;
      issue(16'h0200, 1'b0, 4'hF, '0, g, ben, baddr, ren, raddr, rv);
      issue(16'h0204, 1'b0, 4'hF, '0, g, ben, baddr, ren, raddr, rv);
      rst = 1'b1;
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (rvalid_o !== 1'b0)
            $display("FAIL rstmid_rvalid[%0d]: got %b, expected 0", i, rvalid_o); else passed++;
      end
      @(posedge clk); #1;
      rready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         issue(AW'(16'h0300 + i * 4), 1'b0, 4'hF, '0, g, ben, baddr, ren, raddr, rv);
         checks++; if (g !== (i < 2))
            $display("FAIL rstmid_gnt[%0d]: got %b, expected %b", i, g, (i < 2)); else passed++;
      end
      drain();
   endtask

   initial begin
      rst = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0;
      wdata_i = '0; rready_i = 1'b0;
      test_reset();
      test_interleave();
      test_backpressure();
      test_back_to_back();
      test_ram_write();
      test_rom();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
